// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch, data) arbiter in front of a single-port
// memory with fixed read latency. One transaction is outstanding at a time.
// Data requests win by default. Fetch wins once data has been granted
// STARVE_MAX times in a row while fetch was waiting.
module mem_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] fetch_stall_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;
   localparam int SW = $clog2(STARVE_MAX + 2);

   logic [0:0]    state_r;
   logic [2:0]    cnt_r;
   logic          owner_d_r;
   logic          store_r;
   logic [SW-1:0] starve_r;
   logic [31:0]   if_rdata_r;
   logic [31:0]   d_rdata_r;
   logic [31:0]   stall_r;

   logic          idle_s;
   logic          fetch_win_s;
   logic          done_s;

   assign idle_s      = rst && (state_r == ST_IDLE);
   assign fetch_win_s = if_req && (!d_req || (starve_r == SW'(STARVE_MAX)));
   assign done_s      = rst && (state_r == ST_WAIT) && (cnt_r == 3'd1);

   assign if_rvalid = done_s && !owner_d_r;
   assign d_rvalid  = done_s && owner_d_r;
   // The owner sees this cycle's memory data; everyone else keeps the last value.
   assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_r;
   assign d_rdata   = d_rvalid ? (store_r ? 32'h0000_0000 : mem_rdata) : d_rdata_r;
   assign fetch_stall_cnt = stall_r;

   // Grant selection and memory command mux; all-zero command without a grant.
   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 4'b0000;
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      if (idle_s && fetch_win_s) begin
         if_gnt   = 1'b1;
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end else if (idle_s && d_req) begin
         d_gnt     = 1'b1;
         mem_en    = 1'b1;
         mem_we    = d_we ? d_be : 4'b0000;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else begin
         mem_en = 1'b0;
      end
   end

   // FSM: IDLE issues a command, WAIT counts the memory latency down to rvalid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 3'd0;
         owner_d_r <= 1'b0;
         store_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (if_gnt || d_gnt) begin
                  state_r   <= ST_WAIT;
                  cnt_r     <= 3'(MEM_LAT);
                  owner_d_r <= d_gnt;
                  store_r   <= d_gnt && d_we;
               end
            end
            ST_WAIT: begin
               cnt_r <= cnt_r - 3'd1;
               if (cnt_r == 3'd1) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 3'd0;
            end
         endcase
      end
   end

   // Starvation counter: consecutive data grants while fetch is waiting.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_r <= '0;
      end else if (if_gnt) begin
         starve_r <= '0;
      end else if (d_gnt && if_req && (starve_r != SW'(STARVE_MAX))) begin
         starve_r <= starve_r + 1'b1;
      end
   end

   // Saturating count of cycles in which fetch requested but was not granted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_r <= 32'h0000_0000;
      end else if (if_req && !if_gnt && (stall_r != 32'hFFFF_FFFF)) begin
         stall_r <= stall_r + 32'd1;
      end
   end

   // Read data holding registers, refreshed only when their owner completes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if_rdata_r <= 32'h0000_0000;
         d_rdata_r  <= 32'h0000_0000;
      end else begin
         if (if_rvalid) begin
            if_rdata_r <= if_rdata;
         end
         if (d_rvalid) begin
            d_rdata_r <= d_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [3:0]  d_be = 4'h0;
   logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] fetch_stall_cnt;

   int total = 0;
   int bad = 0;

   mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .fetch_stall_cnt(fetch_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80;
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b want 0/0", if_gnt, d_gnt); end
         total++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem: mem_en=%b mem_addr=%h want 0/0", mem_en, mem_addr); end
         total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: if=%b d=%b want 0/0", if_rvalid, d_rvalid); end
         total++; if (fetch_stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_stall: got %0d want 0", fetch_stall_cnt); end
         total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: if=%h d=%h want 0/0", if_rdata, d_rdata); end
         tick();
      end
      do_reset();
   endtask

   task automatic test_fetch;
      do_reset();
      mem_rdata = 32'h0000_0013; if_req = 1'b1; if_addr = 32'h100;
      #1; // cycle T
      total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b want 1/0", if_gnt, d_gnt); end
      total++; if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 4'b0000) begin bad++; $display("FAIL fetch_cmd: en=%b addr=%h we=%b want 1/100/0000", mem_en, mem_addr, mem_we); end
      tick(); #1; // T+1, request still held
      total++; if (if_gnt !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL fetch_wait1: gnt=%b en=%b addr=%h want 0/0/0", if_gnt, mem_en, mem_addr); end
      total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_early_rvalid: got %b want 0", if_rvalid); end
      tick(); #1; // T+2
      total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin bad++; $display("FAIL fetch_rvalid: rvalid=%b rdata=%h want 1/00000013", if_rvalid, if_rdata); end
      total++; if (if_gnt !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin bad++; $display("FAIL fetch_t2_other: gnt=%b d_rvalid=%b d_rdata=%h want 0/0/0", if_gnt, d_rvalid, d_rdata); end
      tick(); #1; // T+3: second grant
      total++; if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_t3_gnt: gnt=%b rvalid=%b want 1/0", if_gnt, if_rvalid); end
      total++; if (fetch_stall_cnt !== 32'd2) begin bad++; $display("FAIL fetch_stall: got %0d want 2", fetch_stall_cnt); end
      total++; if (if_rdata !== 32'h13) begin bad++; $display("FAIL fetch_hold: got %h want 00000013", if_rdata); end
      tick(); if_req = 1'b0; // T+4
      tick(); mem_rdata = 32'h55; #1; // T+5
      total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55) begin bad++; $display("FAIL fetch2_rvalid: rvalid=%b rdata=%h want 1/00000055", if_rvalid, if_rdata); end
      tick(); mem_rdata = 32'h0; #1; // T+6
      total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h55) begin bad++; $display("FAIL fetch2_hold: rvalid=%b rdata=%h want 0/00000055", if_rvalid, if_rdata); end
   endtask

   task automatic test_starve;
      logic [9:0] fetch_slot;
      logic [31:0] exp_stall;
      logic exp_if, exp_d, last_f;
      fetch_slot = 10'b10000_10000; // bit i set: grant i goes to fetch
      exp_stall = 32'h0; last_f = 1'b0;
      do_reset();
      mem_rdata = 32'h0000_00AA; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      if_addr = 32'h1000; d_addr = 32'h2000;
      for (int k = 0; k < 30; k++) begin
         #1;
         exp_if = (k % 3 == 0) && fetch_slot[k/3];
         exp_d  = (k % 3 == 0) && !fetch_slot[k/3];
         if (k % 3 == 0) last_f = fetch_slot[k/3];
         total++; if (if_gnt !== exp_if || d_gnt !== exp_d) begin bad++; $display("FAIL starve_order cyc%0d: if_gnt=%b d_gnt=%b want %b/%b", k, if_gnt, d_gnt, exp_if, exp_d); end
         total++; if (fetch_stall_cnt !== exp_stall) begin bad++; $display("FAIL starve_stall cyc%0d: got %0d want %0d", k, fetch_stall_cnt, exp_stall); end
         if (k % 3 == 2) begin
            total++; if (if_rvalid !== last_f || d_rvalid !== !last_f) begin bad++; $display("FAIL starve_rvalid cyc%0d: if=%b d=%b want %b/%b", k, if_rvalid, d_rvalid, last_f, !last_f); end
            total++; if (last_f ? (if_rdata !== 32'hAA) : (d_rdata !== 32'hAA)) begin bad++; $display("FAIL starve_rdata cyc%0d: if=%h d=%h want 000000aa on owner", k, if_rdata, d_rdata); end
         end
         if (!exp_if) exp_stall = exp_stall + 32'd1;
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();
   endtask

   task automatic test_store;
      do_reset();
      mem_rdata = 32'h1234_5678;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h204; d_wdata = 32'h0;
      #1;
      total++; if (d_gnt !== 1'b1 || mem_we !== 4'b0000 || mem_addr !== 32'h204) begin bad++; $display("FAIL load_cmd: gnt=%b we=%b addr=%h want 1/0000/204", d_gnt, mem_we, mem_addr); end
      tick(); d_req = 1'b0;
      tick(); #1;
      total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) begin bad++; $display("FAIL load_rvalid: rvalid=%b rdata=%h want 1/12345678", d_rvalid, d_rdata); end
      tick();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
      #1;
      total++; if (d_gnt !== 1'b1 || mem_en !== 1'b1) begin bad++; $display("FAIL store_gnt: gnt=%b en=%b want 1/1", d_gnt, mem_en); end
      total++; if (mem_we !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin bad++; $display("FAIL store_cmd: we=%b wdata=%h addr=%h want 0011/deadbeef/200", mem_we, mem_wdata, mem_addr); end
      tick(); d_req = 1'b0; d_we = 1'b0; #1;
      total++; if (mem_we !== 4'b0000 || mem_wdata !== 32'h0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL store_wait: we=%b wdata=%h rvalid=%b want 0000/0/0", mem_we, mem_wdata, d_rvalid); end
      total++; if (d_rdata !== 32'h1234_5678) begin bad++; $display("FAIL store_hold: got %h want 12345678", d_rdata); end
      tick(); #1;
      total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin bad++; $display("FAIL store_rvalid: rvalid=%b rdata=%h want 1/0", d_rvalid, d_rdata); end
      tick();
   endtask

   task automatic test_reset_wait;
      do_reset();
      mem_rdata = 32'h77; if_req = 1'b1; if_addr = 32'h300;
      #1;
      total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rstw_gnt: got %b want 1", if_gnt); end
      tick(); rst = 1'b0; d_req = 1'b1; #1; // T+1 in reset, requests present
      total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL rstw_in_reset: ig=%b dg=%b en=%b rv=%b want 0", if_gnt, d_gnt, mem_en, if_rvalid); end
      tick(); rst = 1'b1; if_req = 1'b0; d_req = 1'b0; #1; // T+2
      total++; if (if_rvalid !== 1'b0 || fetch_stall_cnt !== 32'h0 || if_rdata !== 32'h0) begin bad++; $display("FAIL rstw_t2: rv=%b stall=%0d rdata=%h want 0/0/0", if_rvalid, fetch_stall_cnt, if_rdata); end
      tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h310; #1; // T+3
      total++; if (d_gnt !== 1'b1 || if_rvalid !== 1'b0 || mem_addr !== 32'h310) begin bad++; $display("FAIL rstw_new_gnt: dg=%b rv=%b addr=%h want 1/0/310", d_gnt, if_rvalid, mem_addr); end
      tick(); d_req = 1'b0;
      tick(); #1;
      total++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL rstw_new_rvalid: d=%b if=%b want 1/0", d_rvalid, if_rvalid); end
      tick();
   endtask

   task automatic test_drop;
      do_reset();
      if_req = 1'b1; if_addr = 32'h400;
      #1;
      total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL drop_fetch_gnt: got %b want 1", if_gnt); end
      tick(); if_req = 1'b0; d_req = 1'b1; d_addr = 32'h500; #1; // T+1 pulse
      total++; if (d_gnt !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL drop_pulse: dg=%b en=%b want 0/0", d_gnt, mem_en); end
      tick(); d_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (d_gnt !== 1'b0 || mem_en !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL drop_after%0d: dg=%b en=%b drv=%b want 0/0/0", i, d_gnt, mem_en, d_rvalid); end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fetch();
      test_starve();
      test_store();
      test_reset_wait();
      test_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
